bin_to_bcd_seq: RTL and testbench

- Sequential double-dabble converter. Turns an unsigned binary count (cycle counters, result values) into packed BCD digits.
- Sits directly upstream of the per-digit 7-segment decoder. Each 4-bit output nibble is guaranteed to be in 0..9.
- Start/busy/done handshake. One add-3-and-shift iteration per clock, so no wide combinational divider is needed.

---
 rtl/bin_to_bcd_seq_pkg.sv | 22 ++
 rtl/bin_to_bcd_seq_add3.sv | 8 +
 rtl/bin_to_bcd_seq.sv | 102 ++++++++++
 tb/tb_bin_to_bcd_seq.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared constants for the binary-to-BCD converter and the display path.
package bin_to_bcd_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int         DEF_BIN_W  = 14;
  localparam int         DEF_DIGITS = 4;
  localparam logic [3:0] BCD_NINE   = 4'd9;

  // 10^n, used to size the largest representable value.
  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/bin_to_bcd_seq_add3.sv
// Double-dabble nibble correction: bump any digit >= 5 by 3 ahead of the shift.
module bcd_add3 (
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);
  // 4-bit add; results stay within 8..12 so nothing carries out.
  assign nib_o = (nib_i >= 4'd5) ? nib_i + 4'd3 : nib_i;
endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble: one add-3/shift iteration per clock, start/busy/done handshake.
module bin_to_bcd_seq
  import bin_to_bcd_seq_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  ovf
);

  localparam int              BCD_W    = 4 * DIGITS;
  localparam int              SR_W     = BCD_W + BIN_W;
  localparam int              CNT_W    = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);
  localparam longint unsigned MAX_VAL  = pow10(DIGITS) - 64'd1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SR_W-1:0]    sr_q, sr_d;
  logic               ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic               done_q, done_d;

  logic [DIGITS-1:0][3:0] nib_in, nib_out;
  logic [SR_W-1:0]        sr_adj, sr_shift;

  // Per-digit add-3 correction on the BCD field of the shift register.
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    assign nib_in[g] = sr_q[BIN_W + 4*g +: 4];
    bcd_add3 u_add3 (.nib_i(nib_in[g]), .nib_o(nib_out[g]));
  end

  // The shift-out of the top nibble is dropped; overflow is handled by saturation.
  assign sr_adj   = {nib_out, sr_q[BIN_W-1:0]};
  assign sr_shift = sr_adj << 1;

  // Next-state, iteration and result-publish logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    ovf_pend_d = ovf_pend_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        sr_d       = {{BCD_W{1'b0}}, bin_in};
        cnt_d      = '0;
        ovf_pend_d = (64'(bin_in) > MAX_VAL);
        state_d    = CONV;
      end
      CONV: begin
        sr_d  = sr_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = DONE;
      end
      DONE: begin
        bcd_d   = ovf_pend_q ? {DIGITS{BCD_NINE}} : sr_q[SR_W-1 -: BCD_W];
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and result registers; reset aborts any conversion in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      ovf_pend_q <= 1'b0;
      bcd_q      <= '0;
      ovf_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      ovf_pend_q <= ovf_pend_d;
      bcd_q      <= bcd_d;
      ovf_q      <= ovf_d;
      done_q     <= done_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign bcd_out = bcd_q;
  assign ovf     = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed + random bench for bin_to_bcd_seq with a result scoreboard.
module tb_bin_to_bcd_seq;

  typedef struct packed {
    logic [15:0] bcd;
    logic        ovf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [13:0] bin_in;
  logic        busy, done, ovf;
  logic [15:0] bcd_out;

  int   checks = 0;
  int   errors = 0;
  int   n_done = 0;
  int   n_push = 0;
  exp_t sb[$];

  bin_to_bcd_seq dut (
    .clk(clk), .rst(rst), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .ovf(ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input int v);
    exp_t e;
    if (v > 9999) begin
      e.bcd = 16'h9999;
      e.ovf = 1'b1;
    end else begin
      e.bcd = {4'((v / 1000) % 10), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
      e.ovf = 1'b0;
    end
    return e;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    sb.push_back(model(v));
    n_push++;
  endtask

  // Scoreboard side: every done pulse pops one expected result.
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      logic ok;
      n_done++;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) if (bcd_out[4*i +: 4] > 4'd9) ok = 1'b0;
      chk("nibble_range", 32'(ok), 32'd1);
      chk("done_single_cycle", 32'(done_prev), 32'd0);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("bcd_out", 32'(bcd_out), 32'(e.bcd));
        chk("ovf", 32'(ovf), 32'(e.ovf));
      end
    end
    done_prev = done;
  end

  // Bounded wait for done; returns number of edges waited and busy-high samples.
  task automatic wait_done(output int k, output int nbusy);
    k = 0;
    nbusy = 0;
    while (!done && k < 40) begin
      if (busy) nbusy++;
      tick(1);
      k++;
    end
    if (!done) chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic do_conv(input int v);
    int k, nb;
    exp_t e;
    e = model(v);
    start = 1'b1;
    bin_in = 14'(v);
    push(v);
    tick(1);
    start = 1'b0;
    wait_done(k, nb);
    chk("latency", 32'(k), 32'd15);
    chk("busy_cycles", 32'(nb), 32'd15);
    chk("busy_low_at_done", 32'(busy), 32'd0);
    tick(1);
    chk("done_low_after", 32'(done), 32'd0);
    chk("bcd_held", 32'(bcd_out), 32'(e.bcd));
  endtask

  initial begin
    int k, nb, d0;
    rst = 1'b1;
    start = 1'b0;
    bin_in = '0;
    tick(3);
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd", 32'(bcd_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    tick(1);

    do_conv(1234);
    do_conv(0);
    do_conv(9999);
    do_conv(10000);
    chk("ovf_10000", 32'(ovf), 32'd1);
    do_conv(16383);
    do_conv(42);
    chk("ovf_cleared", 32'(ovf), 32'd0);

    // start during CONV and DONE ignored; start in done cycle accepted
    start = 1'b1; bin_in = 14'd567; push(567);
    tick(1);                     // edge 0
    start = 1'b0;
    tick(2);                     // after edge 2
    start = 1'b1; bin_in = 14'd888;
    tick(1);                     // edge 3, CONV
    start = 1'b0;
    tick(11);                    // after edge 14, DONE state
    chk("busy_in_done_state", 32'(busy), 32'd1);
    chk("done_not_yet", 32'(done), 32'd0);
    start = 1'b1; bin_in = 14'd888;
    tick(1);                     // edge 15: ignored, result published
    chk("done_567", 32'(done), 32'd1);
    chk("bcd_567", 32'(bcd_out), 32'h0567);
    push(888);
    tick(1);                     // edge 16: accepted
    start = 1'b0;
    chk("done_low_16", 32'(done), 32'd0);
    chk("busy_accept_16", 32'(busy), 32'd1);
    wait_done(k, nb);
    chk("latency_888", 32'(k), 32'd15);
    chk("bcd_888", 32'(bcd_out), 32'h0888);
    tick(1);

    // reset mid-conversion
    d0 = n_done;
    start = 1'b1; bin_in = 14'd4321;
    tick(1);
    start = 1'b0;
    tick(6);
    rst = 1'b1;
    tick(1);                     // edge 7 with reset
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd", 32'(bcd_out), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    tick(20);
    chk("abort_no_done", 32'(n_done - d0), 32'd0);
    do_conv(4321);

    // random sweep
    for (int i = 0; i < 200; i++) do_conv(int'($urandom_range(0, 16383)));

    tick(2);
    chk("done_count", 32'(n_done), 32'(n_push));
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
